// File: rtl/pe_psum_requant_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_psum_requant_if
// Description : Input-beat and output-result stream bundle of the psum
//               requantizer (producer/consumer = master, requantizer = slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_psum_requant_if #(
    parameter int W = 8,
    parameter int N = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][2*W-1:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N-1:0][W-1:0]       out_data;
    logic                      sat_flag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/pe_psum_requant.sv
`default_nettype none
// ============================================================================
// Module      : pe_psum_requant
// Description : Accumulates num_tiles partial-sum vectors per lane, then
//               round-half-up shifts and saturates each lane to W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_psum_requant #(
    parameter int W     = 8,
    parameter int N     = 16,
    parameter int CNT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_num_tiles_i,
    input  logic [4:0]       cfg_shift_i,
    output logic             busy_o,
    pe_psum_requant_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_QUANT  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic signed [ACC_W:0] c_one  = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] c_qmax = (c_one <<< (W-1)) - c_one;
    localparam logic signed [ACC_W:0] c_qmin = -(c_one <<< (W-1));

    if (ACC_W < 2*W + CNT_W) begin : g_acc_w_check
        $error("pe_psum_requant: ACC_W must be >= 2*W+CNT_W");
    end

    state_t                     state_q, state_d;
    logic [N-1:0][ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]           tile_cnt_q;
    logic [CNT_W-1:0]           num_tiles_q;
    logic [4:0]                 shift_q;
    logic [N-1:0][W-1:0]        out_data_q;
    logic                       out_valid_q;
    logic                       sat_q;

    logic                       w_load;
    logic                       w_beat;
    logic                       w_quant;
    logic                       w_hshake;
    logic [N-1:0][W-1:0]        w_lane_q;
    logic [N-1:0]               w_lane_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_load   = 1'b0;
        w_beat   = 1'b0;
        w_quant  = 1'b0;
        w_hshake = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_load  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    w_beat = 1'b1;
                    if (tile_cnt_q == (num_tiles_q - CNT_W'(1))) begin
                        state_d = S_QUANT;
                    end
                end
            end
            S_QUANT: begin
                w_quant = 1'b1;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    w_hshake = 1'b1;
                    // A start on the handshake cycle chains the next job with no idle gap
                    if (start_i) begin
                        w_load  = 1'b1;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            tile_cnt_q  <= '0;
            num_tiles_q <= CNT_W'(1);
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            if (w_load) begin
                acc_q       <= '0;
                tile_cnt_q  <= '0;
                num_tiles_q <= (cfg_num_tiles_i == '0) ? CNT_W'(1) : cfg_num_tiles_i;
                shift_q     <= cfg_shift_i;
            end else if (w_beat) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[j] <= acc_q[j]
                              + {{(ACC_W-2*W){bus.in_data[j][2*W-1]}}, bus.in_data[j]};
                end
                tile_cnt_q <= tile_cnt_q + CNT_W'(1);
            end

            if (w_quant) begin
                out_data_q  <= w_lane_q;
                sat_q       <= |w_lane_sat;
                out_valid_q <= 1'b1;
            end else if (w_hshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shr;
        logic [W-1:0]          lane;
        logic                  sat;

        always_comb begin
            ext = {acc_q[j][ACC_W-1], acc_q[j]};
            rnd = ext;
            if (shift_q == 5'd0) begin
                shr = ext;
            end else if (32'(shift_q) >= ACC_W) begin
                shr = {(ACC_W+1){ext[ACC_W]}};
            end else begin
                rnd = ext + (c_one <<< (shift_q - 5'd1));
                shr = rnd >>> shift_q;
            end

            sat  = 1'b0;
            lane = shr[W-1:0];
            if (shr > c_qmax) begin
                sat  = 1'b1;
                lane = c_qmax[W-1:0];
            end else if (shr < c_qmin) begin
                sat  = 1'b1;
                lane = c_qmin[W-1:0];
            end
        end

        assign w_lane_q[j]   = lane;
        assign w_lane_sat[j] = sat;
    end

    assign busy_o        = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_psum_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_psum_requant
// Description : Scoreboard bench for pe_psum_requant; results are modelled at
//               job launch and compared when the output handshake occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_psum_requant;
    localparam int W     = 8;
    localparam int N     = 16;
    localparam int CNT_W = 8;
    localparam int ACC_W = 32;

    typedef struct packed {
        logic [N-1:0][W-1:0] d;
        logic                s;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_nt = '0;
    logic [4:0]       cfg_sh = '0;
    logic             busy;

    pe_psum_requant_if #(.W(W), .N(N)) bus ();

    pe_psum_requant #(.W(W), .N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .cfg_num_tiles_i (cfg_nt),
        .cfg_shift_i     (cfg_sh),
        .busy_o          (busy),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int                  checks = 0;
    int                  errors = 0;
    int                  cyc = 0;
    int                  last_beat_cyc = 0;
    int                  beats [0:7][0:N-1];
    exp_t                q[$];
    exp_t                mon_e;
    logic [N-1:0][W-1:0] last_d = '0;
    logic                last_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted result is popped and compared
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output data=%h sat=%b", bus.out_data, bus.sat_flag);
            end else begin
                mon_e = q.pop_front();
                if (bus.out_data !== mon_e.d || bus.sat_flag !== mon_e.s) begin
                    errors++;
                    $display("FAIL result got data=%h sat=%b exp data=%h sat=%b",
                             bus.out_data, bus.sat_flag, mon_e.d, mon_e.s);
                end
            end
            last_d = bus.out_data;
            last_s = bus.sat_flag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < N; j++)
                beats[b][j] = 0;
    endtask

    task automatic push_expected(input int nt, input int sh);
        exp_t   e;
        longint a;
        longint r;
        int     eff;
        eff = (nt == 0) ? 1 : nt;
        e   = '0;
        for (int j = 0; j < N; j++) begin
            a = 0;
            for (int b = 0; b < eff; b++) a += longint'(beats[b][j]);
            if (sh == 0) r = a;
            else         r = (a + (longint'(1) <<< (sh - 1))) >>> sh;
            if (r > 127) begin
                r = 127;
                e.s = 1'b1;
            end else if (r < -128) begin
                r = -128;
                e.s = 1'b1;
            end
            e.d[j] = W'(r);
        end
        q.push_back(e);
    endtask

    task automatic start_job(input int nt, input int sh);
        start  = 1'b1;
        cfg_nt = CNT_W'(nt);
        cfg_sh = 5'(sh);
        tick();
        start  = 1'b0;
    endtask

    task automatic send_beats(input int first, input int n, input int gap);
        bit ok;
        for (int b = first; b < first + n; b++) begin
            bus.in_valid = 1'b1;
            for (int j = 0; j < N; j++) bus.in_data[j] = 16'(beats[b][j]);
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    last_beat_cyc = cyc;
                end
                tick();
            end
            bus.in_valid = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL beat_accept got in_ready=0 for 50 cycles exp 1");
            end
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input bit rnd_ready);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) done = 1'b1;
            tick();
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain got pending=%0d busy=%b exp 0/0", q.size(), busy);
        end
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL out_valid_timeout got 0 exp 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks += 5;
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        if (bus.out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        if (bus.sat_flag !== 1'b0)  begin errors++; $display("FAIL reset_sat got %b exp 0", bus.sat_flag); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        bit found;
        clear_beats();
        for (int j = 0; j < N; j++) beats[0][j] = j;
        bus.out_ready = 1'b1;
        push_expected(1, 0);
        start_job(1, 0);
        send_beats(0, 1, 0);
        wait_valid(found);
        checks++;
        if (!found || cyc - last_beat_cyc != 2) begin
            errors++;
            $display("FAIL latency got %0d exp 2", cyc - last_beat_cyc);
        end
        wait_idle(1'b0);
        checks++;
        if (last_d[N-1] !== W'(N-1) || last_s !== 1'b0) begin
            errors++;
            $display("FAIL identity_lane got %h sat=%b exp %h sat=0", last_d[N-1], last_s, W'(N-1));
        end
    endtask

    task automatic test_rounding();
        clear_beats();
        beats[0][0] = 100;  beats[1][0] = 200; beats[2][0] = -50;
        beats[0][1] = -6;
        for (int j = 2; j < N; j++)
            for (int b = 0; b < 3; b++) beats[b][j] = int'($urandom_range(0, 200)) - 100;
        push_expected(3, 2);
        start_job(3, 2);
        send_beats(0, 1, 0);
        // A start while accumulating must not disturb the running job
        start_job(1, 0);
        send_beats(1, 2, 1);
        wait_idle(1'b0);
        checks += 2;
        if (last_d[0] !== 8'd63)   begin errors++; $display("FAIL round_lane0 got %h exp 3f", last_d[0]); end
        if (last_d[1] !== 8'hFF)   begin errors++; $display("FAIL round_lane1 got %h exp ff", last_d[1]); end
    endtask

    task automatic test_saturate();
        clear_beats();
        beats[0][0] = 1000;  beats[1][0] = 1000;
        beats[0][1] = -1000; beats[1][1] = -1000;
        push_expected(2, 0);
        start_job(2, 0);
        send_beats(0, 2, 0);
        wait_idle(1'b0);
        checks += 3;
        if (last_d[0] !== 8'h7F) begin errors++; $display("FAIL sat_pos got %h exp 7f", last_d[0]); end
        if (last_d[1] !== 8'h80) begin errors++; $display("FAIL sat_neg got %h exp 80", last_d[1]); end
        if (last_s !== 1'b1)     begin errors++; $display("FAIL sat_flag got %b exp 1", last_s); end
    endtask

    task automatic test_stall();
        bit                  found;
        logic [N-1:0][W-1:0] cap_d;
        logic                cap_s;
        clear_beats();
        for (int j = 0; j < N; j++) beats[0][j] = int'($urandom_range(0, 4000)) - 2000;
        bus.out_ready = 1'b0;
        push_expected(1, 3);
        start_job(1, 3);
        send_beats(0, 1, 0);
        wait_valid(found);
        cap_d = bus.out_data;
        cap_s = bus.sat_flag;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            for (int j = 0; j < N; j++) bus.in_data[j] = 16'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.sat_flag, bus.out_data} !== {2'b10, cap_s, cap_d}) begin
                errors++;
                $display("FAIL stall_hold got v=%b rdy=%b sat=%b d=%h exp v=1 rdy=0 sat=%b d=%h",
                         bus.out_valid, bus.in_ready, bus.sat_flag, bus.out_data, cap_s, cap_d);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle(1'b0);
    endtask

    task automatic test_reset_mid();
        clear_beats();
        for (int j = 0; j < N; j++) begin
            beats[0][j] = 30;
            beats[1][j] = -70;
        end
        start_job(4, 0);
        send_beats(0, 2, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.in_ready, bus.out_valid, bus.sat_flag, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL midjob_reset got busy=%b rdy=%b v=%b sat=%b d=%h exp all 0",
                     busy, bus.in_ready, bus.out_valid, bus.sat_flag, bus.out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_beats();
        beats[0][0] = 5;
        push_expected(1, 0);
        start_job(1, 0);
        send_beats(0, 1, 0);
        wait_idle(1'b0);
        checks++;
        if (last_d[0] !== 8'd5) begin errors++; $display("FAIL no_residue got %h exp 05", last_d[0]); end
    endtask

    task automatic test_back_to_back();
        bit found;
        clear_beats();
        for (int j = 0; j < N; j++) beats[0][j] = int'($urandom_range(0, 600)) - 300;
        bus.out_ready = 1'b0;
        push_expected(0, 1);
        start_job(0, 1);
        repeat (3) tick();
        send_beats(0, 1, 0);
        wait_valid(found);
        tick();
        clear_beats();
        for (int j = 0; j < N; j++) begin
            beats[0][j] = int'($urandom_range(0, 20000)) - 10000;
            beats[1][j] = int'($urandom_range(0, 20000)) - 10000;
        end
        push_expected(2, 7);
        bus.out_ready = 1'b1;
        start_job(2, 7);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL chain_accum got busy=%b rdy=%b exp 1/1", busy, bus.in_ready);
        end
        tick();
        send_beats(0, 2, 2);
        wait_idle(1'b0);
    endtask

    task automatic test_random();
        int nt;
        int sh;
        for (int t = 0; t < 6; t++) begin
            nt = int'($urandom_range(1, 4));
            sh = int'($urandom_range(0, 12));
            clear_beats();
            for (int b = 0; b < nt; b++)
                for (int j = 0; j < N; j++) beats[b][j] = int'($urandom_range(0, 65535)) - 32768;
            push_expected(nt, sh);
            start_job(nt, sh);
            send_beats(0, nt, t % 2);
            wait_idle(1'b1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_rounding();
        test_saturate();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_results got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
